// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: FSM states, owner encoding and counter sizing.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    READ,
    WRITE
  } t_arb_state;

  typedef enum logic {
    OWNER_IF,
    OWNER_DM
  } t_owner;

  localparam int unsigned MIN_BEATS = 2;

  // Beat counter width; BEATS is a power of two >= MIN_BEATS.
  function automatic int unsigned cnt_width(input int unsigned beats);
    return (beats > MIN_BEATS) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/mem_arb_picker.sv
// Combinational two-way picker; round-robin by default, fixed data priority when
// MEM_ARB_DATA_PRIORITY_EN is defined.
module mem_arb_picker
  import mem_arb_pkg::*;
(
  input  logic       req_if,
  input  logic       req_dm,
  input  t_owner     last_owner,
  output logic [1:0] gnt          // bit 0 = fetch, bit 1 = data
);

  always_comb begin
    gnt = 2'b00;
    if (req_if && req_dm) begin
`ifdef MEM_ARB_DATA_PRIORITY_EN
      gnt = 2'b10;
`else
      gnt = (last_owner == OWNER_DM) ? 2'b01 : 2'b10;
`endif
    end else if (req_if) begin
      gnt = 2'b01;
    end else if (req_dm) begin
      gnt = 2'b10;
    end
  end

`ifdef MEM_ARB_DATA_PRIORITY_EN
  logic unused_last_owner;
  assign unused_last_owner = (last_owner == OWNER_DM);
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between fetch refills and data line transfers.
// Arbitration policy selectable with MEM_ARB_DATA_PRIORITY_EN (see mem_arb_picker).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned BEATS      = 8
) (
  input  logic                  i_clk,
  input  logic                  i_arstn,
  input  logic                  i_if_req,
  input  logic [ADDR_WIDTH-1:0] i_if_addr,
  output logic                  o_if_gnt,
  output logic                  o_if_rvalid,
  output logic                  o_if_done,
  input  logic                  i_dm_req,
  input  logic                  i_dm_we,
  input  logic [ADDR_WIDTH-1:0] i_dm_addr,
  input  logic [DATA_WIDTH-1:0] i_dm_wdata,
  output logic                  o_dm_gnt,
  output logic                  o_dm_rvalid,
  output logic                  o_dm_wready,
  output logic                  o_dm_done,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_mem_valid,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic                  i_mem_ready,
  output logic                  o_mem_wvalid,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic                  i_mem_wready,
  input  logic                  i_mem_rvalid,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

  localparam int unsigned CW = cnt_width(BEATS);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  t_arb_state            state_q, state_d;
  t_owner                owner_q, owner_d;
  t_owner                last_owner_q, last_owner_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  if_gnt_q, if_gnt_d, dm_gnt_q, dm_gnt_d;
  logic                  if_done_q, if_done_d, dm_done_q, dm_done_d;
  logic [1:0]            pick;
  logic                  beat_hs;
  logic                  last_beat;

  mem_arb_picker u_picker (
    .req_if     (i_if_req),
    .req_dm     (i_dm_req),
    .last_owner (last_owner_q),
    .gnt        (pick)
  );

  // Handshakes only count in their own phase; stray strobes elsewhere are ignored.
  assign beat_hs   = ((state_q == READ) && i_mem_rvalid) || ((state_q == WRITE) && i_mem_wready);
  assign last_beat = beat_hs && (cnt_q == LAST_BEAT);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    addr_d       = addr_q;
    we_d         = we_q;
    cnt_d        = cnt_q;
    if_gnt_d     = 1'b0;
    dm_gnt_d     = 1'b0;
    if_done_d    = 1'b0;
    dm_done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick != 2'b00) begin
          owner_d  = pick[1] ? OWNER_DM : OWNER_IF;
          addr_d   = pick[1] ? i_dm_addr : i_if_addr;
          we_d     = pick[1] & i_dm_we;
          if_gnt_d = pick[0];
          dm_gnt_d = pick[1];
          state_d  = ADDR;
        end
      end
      ADDR: begin
        if (i_mem_ready) begin
          state_d = we_q ? WRITE : READ;
          cnt_d   = '0;
        end
      end
      READ, WRITE: begin
        if (beat_hs) begin
          cnt_d = last_beat ? '0 : cnt_q + CW'(1);
          if (last_beat) begin
            state_d      = IDLE;
            last_owner_d = owner_q;
            if_done_d    = (owner_q == OWNER_IF);
            dm_done_d    = (owner_q == OWNER_DM);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      state_q      <= IDLE;
      owner_q      <= OWNER_IF;
      last_owner_q <= OWNER_DM;
      addr_q       <= '0;
      we_q         <= 1'b0;
      cnt_q        <= '0;
      if_gnt_q     <= 1'b0;
      dm_gnt_q     <= 1'b0;
      if_done_q    <= 1'b0;
      dm_done_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      cnt_q        <= cnt_d;
      if_gnt_q     <= if_gnt_d;
      dm_gnt_q     <= dm_gnt_d;
      if_done_q    <= if_done_d;
      dm_done_q    <= dm_done_d;
    end
  end

  assign o_if_gnt     = if_gnt_q;
  assign o_dm_gnt     = dm_gnt_q;
  assign o_if_done    = if_done_q;
  assign o_dm_done    = dm_done_q;
  assign o_mem_valid  = (state_q == ADDR);
  assign o_mem_we     = we_q;
  assign o_mem_addr   = addr_q;
  assign o_if_rvalid  = (state_q == READ) && i_mem_rvalid && (owner_q == OWNER_IF);
  assign o_dm_rvalid  = (state_q == READ) && i_mem_rvalid && (owner_q == OWNER_DM);
  assign o_rdata      = ((state_q == READ) && i_mem_rvalid) ? i_mem_rdata : '0;
  assign o_mem_wvalid = (state_q == WRITE);
  assign o_dm_wready  = (state_q == WRITE) && i_mem_wready;
  assign o_mem_wdata  = (state_q == WRITE) ? i_dm_wdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (BEATS=4) against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int NB = 4;

  logic        clk = 1'b0;
  logic        arstn = 1'b0;
  logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic [63:0] if_addr = '0, dm_addr = '0, dm_wdata = '0, mem_rdata = '0;
  logic        mem_ready = 1'b0, mem_wready = 1'b0, mem_rvalid = 1'b0;
  logic        o_if_gnt, o_if_rvalid, o_if_done, o_dm_gnt, o_dm_rvalid, o_dm_wready, o_dm_done;
  logic        o_mem_valid, o_mem_we, o_mem_wvalid;
  logic [63:0] o_rdata, o_mem_addr, o_mem_wdata;

  int total = 0;
  int bad = 0;
  bit last_owner_dm = 1'b1;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_WIDTH (64),
    .DATA_WIDTH (64),
    .BEATS      (NB)
  ) dut (
    .i_clk        (clk),
    .i_arstn      (arstn),
    .i_if_req     (if_req),
    .i_if_addr    (if_addr),
    .o_if_gnt     (o_if_gnt),
    .o_if_rvalid  (o_if_rvalid),
    .o_if_done    (o_if_done),
    .i_dm_req     (dm_req),
    .i_dm_we      (dm_we),
    .i_dm_addr    (dm_addr),
    .i_dm_wdata   (dm_wdata),
    .o_dm_gnt     (o_dm_gnt),
    .o_dm_rvalid  (o_dm_rvalid),
    .o_dm_wready  (o_dm_wready),
    .o_dm_done    (o_dm_done),
    .o_rdata      (o_rdata),
    .o_mem_valid  (o_mem_valid),
    .o_mem_we     (o_mem_we),
    .o_mem_addr   (o_mem_addr),
    .i_mem_ready  (mem_ready),
    .o_mem_wvalid (o_mem_wvalid),
    .o_mem_wdata  (o_mem_wdata),
    .i_mem_wready (mem_wready),
    .i_mem_rvalid (mem_rvalid),
    .i_mem_rdata  (mem_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit outs_zero();
    return ({o_if_gnt, o_if_rvalid, o_if_done, o_dm_gnt, o_dm_rvalid, o_dm_wready, o_dm_done,
             o_rdata, o_mem_valid, o_mem_we, o_mem_addr, o_mem_wvalid, o_mem_wdata} === '0);
  endfunction

  // Arbitration rule: sole requester wins; on a tie the port not used last wins.
  function automatic bit pick_dm(input logic ri, input logic rd);
`ifdef MEM_ARB_DATA_PRIORITY_EN
    if (ri && rd) return 1'b1;
`else
    if (ri && rd) return !last_owner_dm;
`endif
    return rd;
  endfunction

  task automatic apply_reset();
    arstn = 1'b0;
    {if_req, dm_req, mem_ready, mem_wready, mem_rvalid} = '0;
    #1;
    chk("rst_outs_low", outs_zero(), 1);
    step();
    step();
    arstn = 1'b1;
    last_owner_dm = 1'b1;
    #1;
    chk("rst_outs_released", outs_zero(), 1);
  endtask

  // Runs one transaction from the IDLE cycle where requests are sampled to the done cycle.
  task automatic do_txn(input int rdy_delay, input bit wr_toggle);
    bit          exp_dm, hs;
    logic        exp_we;
    logic [63:0] exp_a, d;
    int          n, budget;
    exp_dm = pick_dm(if_req, dm_req);
    exp_we = exp_dm ? dm_we : 1'b0;
    exp_a  = exp_dm ? dm_addr : if_addr;
    step();
    chk("if_gnt", o_if_gnt, !exp_dm);
    chk("dm_gnt", o_dm_gnt, exp_dm);
    if (exp_dm) dm_req = 1'b0;
    else if_req = 1'b0;
    for (int i = 0; i <= rdy_delay; i++) begin
      mem_ready  = (i == rdy_delay);
      mem_rvalid = (i < rdy_delay);
      mem_wready = (i < rdy_delay);
      mem_rdata  = {$urandom, $urandom};
      #1;
      if (i > 0) chk("gnt_pulse", o_if_gnt | o_dm_gnt, 0);
      chk("addr_valid", o_mem_valid, 1);
      chk("addr_addr", o_mem_addr, exp_a);
      chk("addr_we", o_mem_we, exp_we);
      chk("addr_stray", o_if_rvalid | o_dm_rvalid | o_dm_wready | o_mem_wvalid, 0);
      step();
    end
    mem_ready = 1'b0;
    n = 0;
    budget = 0;
    while (n < NB && budget < 50) begin
      hs = (exp_we && wr_toggle) ? ((budget % 2) == 0) : 1'($urandom_range(0, 1));
      d  = {$urandom, $urandom};
      if (exp_we) begin
        mem_wready = hs;
        mem_rvalid = 1'b1;
        dm_wdata   = d;
      end else begin
        mem_rvalid = hs;
        mem_wready = 1'b1;
        mem_rdata  = d;
      end
      #1;
      if (exp_we) begin
        chk("wr_wvalid", o_mem_wvalid, 1);
        chk("wr_wready", o_dm_wready, hs);
        chk("wr_wdata", o_mem_wdata, d);
        chk("wr_no_rvalid", o_if_rvalid | o_dm_rvalid, 0);
      end else begin
        chk("rd_own_rvalid", exp_dm ? o_dm_rvalid : o_if_rvalid, hs);
        chk("rd_other_rvalid", exp_dm ? o_if_rvalid : o_dm_rvalid, 0);
        if (hs) chk("rd_data", o_rdata, d);
        chk("rd_no_wvalid", o_mem_wvalid | o_dm_wready, 0);
      end
      chk("beat_no_done", o_if_done | o_dm_done, 0);
      chk("beat_no_valid", o_mem_valid, 0);
      if (hs) n++;
      budget++;
      step();
    end
    if (n < NB) chk("beat_timeout", n, NB);
    mem_rvalid = 1'b0;
    mem_wready = 1'b0;
    #1;
    chk("if_done", o_if_done, !exp_dm);
    chk("dm_done", o_dm_done, exp_dm);
    chk("done_idle", o_mem_valid | o_mem_wvalid, 0);
    last_owner_dm = exp_dm;
  endtask

  initial begin
    apply_reset();

    // Fetch only, memory always ready.
    if_req  = 1'b1;
    if_addr = 64'h1000;
    do_txn(0, 1'b0);

    // Simultaneous requests right after reset: fetch first, then data.
    apply_reset();
    if_req  = 1'b1;
    if_addr = 64'h1100;
    dm_req  = 1'b1;
    dm_we   = 1'b0;
    dm_addr = 64'h2200;
    chk("tie_model_fetch_first", pick_dm(if_req, dm_req), 0);
    do_txn(0, 1'b0);
    chk("dm_still_pending", dm_req, 1);
    do_txn(0, 1'b0);

    // Data write with toggling wready.
    dm_req  = 1'b1;
    dm_we   = 1'b1;
    dm_addr = 64'h2000;
    do_txn(0, 1'b1);

    // Address phase stalled five cycles with stray strobes.
    dm_req  = 1'b1;
    dm_we   = 1'b0;
    dm_addr = 64'h2400;
    do_txn(5, 1'b0);

    // Reset in the middle of a read after two beats.
    if_req  = 1'b1;
    if_addr = 64'h3000;
    step();
    if_req    = 1'b0;
    mem_ready = 1'b1;
    step();
    mem_ready  = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 64'hDEAD_BEEF;
    step();
    step();
    arstn = 1'b0;
    #1;
    chk("abort_outs_zero", outs_zero(), 1);
    mem_rvalid = 1'b0;
    step();
    arstn = 1'b1;
    last_owner_dm = 1'b1;
    #1;
    chk("abort_no_done", o_if_done | o_dm_done, 0);
    step();
    chk("abort_idle", outs_zero(), 1);
    if_req  = 1'b1;
    if_addr = 64'h4000;
    do_txn(1, 1'b0);

    // Both requesting continuously for three transactions.
    apply_reset();
    if_addr = 64'h5000;
    dm_addr = 64'h6000;
    dm_we   = 1'b0;
    for (int t = 0; t < 3; t++) begin
      if_req = 1'b1;
      dm_req = 1'b1;
      do_txn(0, 1'b0);
    end
    if_req = 1'b0;
    dm_req = 1'b0;
    step();

    // Randomized traffic.
    for (int t = 0; t < 20; t++) begin
      if (!if_req && $urandom_range(0, 1) == 1) begin
        if_req  = 1'b1;
        if_addr = {$urandom, $urandom} & ~64'h1F;
      end
      if (!dm_req && $urandom_range(0, 1) == 1) begin
        dm_req  = 1'b1;
        dm_we   = 1'($urandom_range(0, 1));
        dm_addr = {$urandom, $urandom} & ~64'h1F;
      end
      if (!if_req && !dm_req) begin
        if_req  = 1'b1;
        if_addr = {$urandom, $urandom} & ~64'h1F;
      end
      do_txn($urandom_range(0, 3), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single external memory port between instruction-fetch refills and data load/store transfers, the latter flagged by the decoder's mem_access and load indications. Each transaction is one address phase followed by BEATS data beats at consecutive word addresses (cache-line granularity). Round-robin arbitration is the default; a compile option switches to fixed data priority. Sits between the fetch/data refill logic and the memory interface.

Parameters:
ADDR_WIDTH, 64, byte address width on all ports.
DATA_WIDTH, 64, width of one data beat.
BEATS, 8, beats per transaction; power of two, 2 or more; counter width $clog2(BEATS).

Ports:
i_clk  in  1  clock.
i_arstn  in  1  asynchronous active-low reset.
i_if_req  in  1  fetch read request; level, held until o_if_gnt.
i_if_addr  in  ADDR_WIDTH  fetch line base address.
o_if_gnt  out  1  one-cycle pulse: fetch request accepted.
o_if_rvalid  out  1  fetch read beat valid.
o_if_done  out  1  one-cycle pulse: fetch transaction complete.
i_dm_req  in  1  data request; level, held until o_dm_gnt.
i_dm_we  in  1  1 = write line, 0 = read line.
i_dm_addr  in  ADDR_WIDTH  data line base address.
i_dm_wdata  in  DATA_WIDTH  current write beat.
o_dm_gnt  out  1  one-cycle pulse: data request accepted.
o_dm_rvalid  out  1  data read beat valid.
o_dm_wready  out  1  write beat consumed this cycle.
o_dm_done  out  1  one-cycle pulse: data transaction complete.
o_rdata  out  DATA_WIDTH  read beat, shared by both requesters; qualify with the rvalid signals.
o_mem_valid  out  1  address phase valid.
o_mem_we  out  1  transaction direction.
o_mem_addr  out  ADDR_WIDTH  latched line base address.
i_mem_ready  in  1  memory accepts address phase.
o_mem_wvalid  out  1  write beat valid.
o_mem_wdata  out  DATA_WIDTH  write beat (i_dm_wdata passed through).
i_mem_wready  in  1  memory accepts write beat.
i_mem_rvalid  in  1  read beat valid.
i_mem_rdata  in  DATA_WIDTH  read beat data.

Behaviour:
- Reset (async, i_arstn=0): state IDLE, beat counter 0, last_owner = DATA, all outputs 0. Reset mid-transaction abandons it silently; no done pulse.
- FSM states: IDLE, ADDR, READ, WRITE.
- IDLE: one request pending → grant it. Both pending → grant the requester that is not last_owner. On grant: latch owner, address and we (fetch forces we=0). Pulse o_*_gnt and enter ADDR; gnt and the state change are both registered.
- ADDR: o_mem_valid=1 and o_mem_addr/o_mem_we held stable until i_mem_ready. On ready: go to READ or WRITE, counter=0.
- READ: each i_mem_rvalid drives o_rdata = i_mem_rdata combinationally. The owner's rvalid is asserted; the other requester's rvalid is 0. Counter increments per beat.
- WRITE: o_mem_wvalid=1 and o_dm_wready = i_mem_wready, both combinational. Counter increments when o_mem_wvalid and i_mem_wready are both 1.
- Last beat (counter = BEATS-1 with handshake): next cycle the state is IDLE, the owner's done pulses, and last_owner = owner. A new grant can issue in that same cycle. The minimum idle gap between transactions is one cycle.
- Stray inputs are ignored: i_mem_rvalid outside READ, i_mem_wready outside WRITE, i_mem_ready outside ADDR.
- Requests are not sampled outside IDLE.
- A requester dropping req after gnt has no effect; the transaction completes.
- Counter wraps to 0 after the last beat.
- The address is never incremented here; memory generates beat addresses.

Optional Feature:
MEM_ARB_DATA_PRIORITY_EN:
- Defined: on simultaneous requests the data port always wins. last_owner is unused, and fetch can be starved by back-to-back data requests.
- Undefined: round-robin as above.

Decomposition:
- Package mem_arb_pkg: enum t_arb_state {IDLE, ADDR, READ, WRITE}; enum t_owner {OWNER_IF, OWNER_DM}; localparam for the counter width function.
- Sub-module mem_arb_picker: combinational 2-input picker (req_if, req_dm, last_owner → grant one-hot). Contains the MEM_ARB_DATA_PRIORITY_EN selection.

Test Plan:
- BEATS=4, only fetch requests addr 0x1000, memory always ready → o_if_gnt at cycle 1, o_mem_valid addr 0x1000 we=0, four o_if_rvalid beats, o_if_done one cycle after beat 4; o_dm_* stay 0.
- Both request in the same cycle right after reset → fetch granted first (last_owner=DATA). Data is granted in the cycle o_if_done pulses, and gets the port next.
- Data write 0x2000 with i_mem_wready toggling 1,0,1,0,... → exactly four write handshakes, o_dm_wready mirrors i_mem_wready, o_dm_done follows the fourth.
- i_mem_ready held 0 for 5 cycles in ADDR → o_mem_valid, o_mem_addr and o_mem_we stable throughout; no beats counted; stray i_mem_rvalid ignored.
- Assert i_arstn=0 after the second read beat → all outputs 0 immediately, state IDLE, no done pulse. A subsequent request restarts with the counter at 0.
- MEM_ARB_DATA_PRIORITY_EN defined, both requesting continuously for three transactions → three consecutive data grants, no fetch grant.
